branch_index_tracker: RTL
=========================

# branch_index_tracker

- Sits between fetch and the 2-bit saturating counter table.
- Generates the gshare-style table read index from low PC bits and a speculative global history register, and turns the counter MSB into a prediction.
- Records every in-flight prediction in a small ordered queue.
- On branch resolution, issues a registered update (index, outcome) to the counter table and flags mispredicts, repairing speculative history from the architectural history.

## Interface
Parameters:
- HISTORY_WIDTH, 3, index/history width (≥2); matches counter table address width
- DEPTH, 4, max in-flight predictions (power of two)

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_lo  in  HISTORY_WIDTH  low PC bits of branch being predicted
- pred_valid  in  1  branch presented for prediction this cycle
- pred_ready  out  1  prediction accepted when pred_valid && pred_ready
- rd_addr  out  HISTORY_WIDTH  table read index, combinational = pc_lo ^ spec_ghr
- rec  in  2  counter value returned combinationally by the table at rd_addr
- pred_taken  out  1  combinational = rec[1]
- res_valid  in  1  oldest in-flight branch resolves this cycle
- res_taken  in  1  actual outcome of that branch
- update  out  1  registered table write strobe
- wr_addr  out  HISTORY_WIDTH  registered table write index
- taken  out  1  registered outcome for table write
- mispredict  out  1  registered one-cycle pulse
- inflight  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- State:
  - spec_ghr and arch_ghr (HISTORY_WIDTH bits each)
  - circular queue of {idx, pred} entries with head/tail pointers and count
- Accept: push {rd_addr, pred_taken}; spec_ghr <= {spec_ghr[HW-2:0], pred_taken}.
- Resolve, only when res_valid and queue not empty:
  - Pop head.
  - arch_ghr <= {arch_ghr[HW-2:0], res_taken}.
  - Next cycle: update=1, wr_addr=head.idx, taken=res_taken.
- miss = res_valid && !empty && (res_taken != head.pred). On miss:
  - Flush the whole queue (count=0, head=tail).
  - spec_ghr <= {arch_ghr[HW-2:0], res_taken}.
  - mispredict=1 next cycle.
- pred_ready = !full && !miss; miss is a combinational path from res_valid/res_taken.
- Simultaneous accept and correct resolve: push and pop both occur; count unchanged; spec_ghr and arch_ghr each shift independently.
- Full queue: pred_ready=0 even if a correct resolve pops the same cycle (no bypass).
- res_valid with empty queue: ignored; update=0, no state change.
- update, taken and mispredict are single-cycle pulses. wr_addr holds its last value when update=0.

## Timing
- Prediction path (pc_lo → rd_addr → rec → pred_taken) is combinational; zero-cycle latency.
- Resolution → update/mispredict: 1 cycle. Table counter changes at the edge after that (2 edges total).
- spec_ghr and inflight reflect an accepted prediction on the next cycle.
- Reset, asynchronous:
  - spec_ghr=0, arch_ghr=0, queue empty, inflight=0
  - update=0, wr_addr=0, taken=0, mispredict=0
  - pred_ready=1 after reset; rd_addr=pc_lo
- Reset mid-operation discards all in-flight entries immediately and suppresses any pending update pulse.

## Configuration
- PRED_STATS_EN defined:
  - Adds outputs pred_count[15:0] and miss_count[15:0].
  - pred_count increments on each resolved branch; miss_count on each miss.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package bp_pkg holds:
  - HISTORY_WIDTH default constant
  - typedef inflight_entry_t (struct: idx[HISTORY_WIDTH-1:0], pred)
  - typedef ghr_t
- One sub-module, pred_queue:
  - circular FIFO of inflight_entry_t with push, pop and flush
  - exposes full, empty, count and head entry
  - flush has priority over push

## Test plan
- Reset → all registered outputs 0, inflight=0, pred_ready=1; pc_lo=3'b110 gives rd_addr=3'b110.
- Predict pc_lo=3'b101, rec=2'b11 → pred_taken=1, next cycle inflight=1, spec_ghr=3'b001, so pc_lo=3'b101 then gives rd_addr=3'b100.
- Resolve that entry with res_taken=1 → next cycle update=1, wr_addr=3'b101, taken=1, mispredict=0, inflight=0.
- Three predictions with rec=2'b10 (spec_ghr 000→111), then resolve oldest with res_taken=0 → pred_ready=0 that cycle; next cycle mispredict=1, update=1, taken=0, inflight=0, spec_ghr=3'b000.
- Fill with 4 predictions → pred_ready=0. Fifth pred_valid is ignored, inflight stays 4. Correct resolve plus pred_valid in the same cycle → no push, inflight=3; push is accepted the following cycle.
- rst asserted mid-cycle with inflight=2 and res_valid=1 → inflight=0 immediately, no update pulse. res_valid on an empty queue after reset → update stays 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor index/tracking logic.
// Holds the default history width and the in-flight entry layout.
package bp_pkg;

  localparam int BP_HISTORY_WIDTH = 3;

  typedef logic [BP_HISTORY_WIDTH-1:0] ghr_t;

  typedef struct packed {
    logic [BP_HISTORY_WIDTH-1:0] idx;
    logic                        pred;
  } inflight_entry_t;

endpackage

// File: rtl/pred_queue.sv
// Ordered circular FIFO of in-flight predictions with push, pop and flush.
// Flush empties the queue and takes priority over a same-cycle push or pop.
module pred_queue
  import bp_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = inflight_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[head_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      head_r  <= tail_r;
      count_r <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, cleared on reset so the head output is never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[tail_r] <= push_data;
    end
  end

endmodule

// File: rtl/branch_index_tracker.sv
// gshare-style read index generation, in-flight prediction tracking and table update.
// Optional macro PRED_STATS_EN adds saturating pred_count/miss_count outputs.
module branch_index_tracker
  import bp_pkg::*;
#(
  parameter int HISTORY_WIDTH = BP_HISTORY_WIDTH,
  parameter int DEPTH         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HISTORY_WIDTH-1:0]  pc_lo,
  input  logic                      pred_valid,
  output logic                      pred_ready,
  output logic [HISTORY_WIDTH-1:0]  rd_addr,
  input  logic [1:0]                rec,
  output logic                      pred_taken,
  input  logic                      res_valid,
  input  logic                      res_taken,
  output logic                      update,
  output logic [HISTORY_WIDTH-1:0]  wr_addr,
  output logic                      taken,
  output logic                      mispredict,
  output logic [$clog2(DEPTH):0]    inflight
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]               pred_count,
  output logic [15:0]               miss_count
`endif
);

  typedef struct packed {
    logic [HISTORY_WIDTH-1:0] idx;
    logic                     pred;
  } entry_t;

  logic [HISTORY_WIDTH-1:0] spec_ghr_r;
  logic [HISTORY_WIDTH-1:0] arch_ghr_r;
  logic [HISTORY_WIDTH-1:0] spec_ghr_next_s;
  entry_t                   head_s;
  entry_t                   push_entry_s;
  logic                     full_s;
  logic                     empty_s;
  logic                     res_fire_s;
  logic                     miss_s;
  logic                     accept_s;
  logic                     rec_unused_s;

  assign rd_addr      = pc_lo ^ spec_ghr_r;
  assign pred_taken   = rec[1];
  assign rec_unused_s = rec[0];

  // A miss blocks acceptance in the same cycle because the history is being repaired.
  assign res_fire_s   = res_valid && !empty_s;
  assign miss_s       = res_fire_s && (res_taken != head_s.pred);
  assign pred_ready   = !full_s && !miss_s;
  assign accept_s     = pred_valid && pred_ready;
  assign push_entry_s = '{idx: rd_addr, pred: pred_taken};

  pred_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_pred_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (accept_s),
    .push_data (push_entry_s),
    .pop       (res_fire_s),
    .flush     (miss_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (inflight),
    .head      (head_s)
  );

  // Speculative history: repaired from architectural history on a miss, else shifted on accept.
  always_comb begin
    spec_ghr_next_s = spec_ghr_r;
    if (miss_s) begin
      spec_ghr_next_s = {arch_ghr_r[HISTORY_WIDTH-2:0], res_taken};
    end else if (accept_s) begin
      spec_ghr_next_s = {spec_ghr_r[HISTORY_WIDTH-2:0], pred_taken};
    end else begin
      spec_ghr_next_s = spec_ghr_r;
    end
  end

  // History registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_ghr_r <= {HISTORY_WIDTH{1'b0}};
      arch_ghr_r <= {HISTORY_WIDTH{1'b0}};
    end else begin
      spec_ghr_r <= spec_ghr_next_s;
      if (res_fire_s) begin
        arch_ghr_r <= {arch_ghr_r[HISTORY_WIDTH-2:0], res_taken};
      end
    end
  end

  // Registered table update and mispredict pulses; wr_addr holds between updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update     <= 1'b0;
      wr_addr    <= {HISTORY_WIDTH{1'b0}};
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      update     <= res_fire_s;
      taken      <= res_fire_s && res_taken;
      mispredict <= miss_s;
      if (res_fire_s) begin
        wr_addr <= head_s.idx;
      end
    end
  end

`ifdef PRED_STATS_EN
  logic [15:0] pred_count_r;
  logic [15:0] miss_count_r;

  // Saturating resolution and miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_count_r <= 16'h0000;
      miss_count_r <= 16'h0000;
    end else begin
      if (res_fire_s && (pred_count_r != 16'hFFFF)) begin
        pred_count_r <= pred_count_r + 16'h0001;
      end
      if (miss_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'h0001;
      end
    end
  end

  assign pred_count = pred_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule
